// File: rtl/sbox_prog_ctrl.sv
// Programming sequencer that streams one DES S-box table (16 words x 4 nibbles)
// through the shared edit port. Optional checksum check: SBOX_PROG_CHECKSUM_EN.
module sbox_prog_ctrl #(
    parameter int NUM_SBOX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_sbox,
    input  logic [7:0]  cmd_expect,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [15:0] data_word,
    input  logic        abort,
    input  logic        dp_busy,
    output logic        dp_hold,
    output logic        edit_sbox,
    output logic [2:0]  sbox_sel,
    output logic [1:0]  row_sel,
    output logic [3:0]  col_sel,
    output logic [3:0]  new_sbox_val,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_DP = 3'd1,
        S_FETCH   = 3'd2,
        S_WRITE   = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  w_q, w_d;
    logic [1:0]  k_q, k_d;
    logic [15:0] word_q, word_d;
    logic [2:0]  sel_q, sel_d;
    logic        reject_q, reject_d;
    logic [3:0]  nib;
    logic        idx_ok;
    logic        fin_err;

    assign nib    = word_q[{k_q, 2'b00} +: 4];
    assign idx_ok = 32'(cmd_sbox) < NUM_SBOX;

`ifdef SBOX_PROG_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] expect_q, expect_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= 8'd0;
            expect_q <= 8'd0;
        end else begin
            sum_q    <= sum_d;
            expect_q <= expect_d;
        end
    end

    always_comb begin
        sum_d    = sum_q;
        expect_d = expect_q;
        if (state_q == S_IDLE && cmd_valid) begin
            sum_d    = 8'd0;
            expect_d = cmd_expect;
        end else if (state_q == S_WRITE && !abort) begin
            sum_d = sum_q + {4'd0, nib};
        end
    end

    assign fin_err = reject_q | (sum_q != expect_q);
`else
    logic unused_expect;
    assign unused_expect = ^cmd_expect;
    assign fin_err       = reject_q;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            w_q      <= 4'd0;
            k_q      <= 2'd0;
            word_q   <= 16'd0;
            sel_q    <= 3'd0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            k_q      <= k_d;
            word_q   <= word_d;
            sel_q    <= sel_d;
            reject_q <= reject_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        k_d      = k_q;
        word_d   = word_q;
        sel_d    = sel_q;
        reject_d = reject_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    sel_d    = cmd_sbox;
                    w_d      = 4'd0;
                    k_d      = 2'd0;
                    reject_d = !idx_ok;
                    state_d  = idx_ok ? S_WAIT_DP : S_FIN;
                end
            end
            S_WAIT_DP: begin
                if (!dp_busy) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (data_valid) begin
                    word_d  = data_word;
                    k_d     = 2'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (k_q == 2'd3) begin
                    k_d = 2'd0;
                    if (w_q == 4'd15) begin
                        state_d = S_FIN;
                    end else begin
                        w_d     = w_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Outputs; a rejected command never stalls the datapath, even in FIN
    always_comb begin
        cmd_ready    = (state_q == S_IDLE);
        data_ready   = (state_q == S_FETCH);
        dp_hold      = (state_q != S_IDLE) && !(state_q == S_FIN && reject_q);
        edit_sbox    = 1'b0;
        sbox_sel     = 3'd0;
        row_sel      = 2'd0;
        col_sel      = 4'd0;
        new_sbox_val = 4'd0;
        done         = 1'b0;
        err          = 1'b0;
        if (state_q == S_WRITE) begin
            edit_sbox    = !abort;
            sbox_sel     = sel_q;
            row_sel      = w_q[3:2];
            col_sel      = {w_q[1:0], k_q};
            new_sbox_val = nib;
        end
        if (state_q == S_FIN) begin
            done = !abort;
            err  = !abort && fin_err;
        end
    end

endmodule

// File: tb/tb_sbox_prog_ctrl.sv
// Directed table-driven bench for sbox_prog_ctrl (NUM_SBOX=6) with an observed
// S-box content model; also covers reset state and mid-load reset.
module tb_sbox_prog_ctrl;
    localparam int NS = 6;
`ifdef SBOX_PROG_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_sbox = 3'd0;
    logic [7:0]  cmd_expect = 8'd0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [15:0] data_word = 16'd0;
    logic        abort = 1'b0;
    logic        dp_busy = 1'b0;
    logic        dp_hold;
    logic        edit_sbox;
    logic [2:0]  sbox_sel;
    logic [1:0]  row_sel;
    logic [3:0]  col_sel;
    logic [3:0]  new_sbox_val;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    sbox_prog_ctrl #(.NUM_SBOX(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sbox(cmd_sbox), .cmd_expect(cmd_expect),
        .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
        .abort(abort), .dp_busy(dp_busy), .dp_hold(dp_hold),
        .edit_sbox(edit_sbox), .sbox_sel(sbox_sel), .row_sel(row_sel),
        .col_sel(col_sel), .new_sbox_val(new_sbox_val),
        .done(done), .err(err)
    );

    typedef struct {
        int          sbox;
        logic [7:0]  expct;
        logic [15:0] pat;
        int          busy;
        int          gap_word;
        int          gap_len;
        int          abort_c;
        int          exp_done;
        int          exp_err;
        int          exp_strobes;
    } vec_t;

    vec_t       vecs [8];
    logic [3:0] mem [8][4][16];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int words, gap_rem, strobes, bad_order, bad_hold, bad_ready;
        int done_c, err_at, rdy_after, last_c;
        logic hold_exp, reject;
        logic [3:0] ev;
        words = 0; gap_rem = v.gap_len; strobes = 0;
        bad_order = 0; bad_hold = 0; bad_ready = 0;
        done_c = -1; err_at = 0; rdy_after = -1;
        last_c = (v.exp_done >= 0) ? v.exp_done : v.abort_c;
        reject = (v.sbox >= NS);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            cmd_valid  = (c == 0);
            cmd_sbox   = 3'(v.sbox);
            cmd_expect = v.expct;
            dp_busy    = (c >= 1 && c <= v.busy);
            data_valid = !(words == v.gap_word && gap_rem > 0);
            data_word  = v.pat;
            abort      = (c == v.abort_c);
            #1;
            if (c == 0) check($sformatf("v%0d_accept_ready", idx), int'(cmd_ready), 1);
            if (data_ready) begin
                if (data_valid) words++;
                else if (words == v.gap_word && gap_rem > 0) gap_rem--;
            end
            if (dp_busy && data_ready) bad_ready++;
            hold_exp = !reject && c >= 1 && c <= last_c;
            if (dp_hold !== hold_exp) bad_hold++;
            if (edit_sbox) begin
                ev = 4'((v.pat >> (4 * (strobes % 4))) & 16'hF);
                if (int'(sbox_sel) != v.sbox || int'(row_sel) != ((strobes >> 4) & 3) ||
                    int'(col_sel) != (strobes & 15) || new_sbox_val != ev)
                    bad_order++;
                mem[sbox_sel][row_sel][col_sel] = new_sbox_val;
                strobes++;
            end else if (c != v.abort_c && {sbox_sel, row_sel, col_sel, new_sbox_val} != 13'd0) begin
                bad_order++;
            end
            if (done && done_c < 0) begin
                done_c = c;
                err_at = int'(err);
            end else if (err && !done) begin
                bad_order++;
            end
            if (c == last_c + 1) begin
                rdy_after = int'(cmd_ready);
                break;
            end
        end
        abort = 1'b0;
        check($sformatf("v%0d_done_cycle", idx), done_c, v.exp_done);
        if (v.exp_done >= 0) check($sformatf("v%0d_err", idx), err_at, v.exp_err);
        check($sformatf("v%0d_strobes", idx), strobes, v.exp_strobes);
        check($sformatf("v%0d_order_bad", idx), bad_order, 0);
        check($sformatf("v%0d_hold_bad", idx), bad_hold, 0);
        check($sformatf("v%0d_ready_in_busy", idx), bad_ready, 0);
        check($sformatf("v%0d_idle_after", idx), rdy_after, 1);
        $display("vec %0d sbox=%0d pat=%h done_c=%0d err=%0d strobes=%0d",
                 idx, v.sbox, v.pat, done_c, err_at, strobes);
    endtask

    initial begin
        for (int s = 0; s < 8; s++)
            for (int r = 0; r < 4; r++)
                for (int q = 0; q < 16; q++)
                    mem[s][r][q] = 4'hF;

        //          sbox expct  pat      busy gapw gapl abrt done err      strobes
        vecs[0] = '{2, 8'h60, 16'h3210, 0,  -1,  0,  -1,  82, 0,       64};
        vecs[1] = '{2, 8'h61, 16'h3210, 0,  -1,  0,  -1,  82, CK,      64};
        vecs[2] = '{7, 8'h00, 16'h3210, 0,  -1,  0,  -1,  1,  1,       0};
        vecs[3] = '{6, 8'h00, 16'h3210, 0,  -1,  0,  -1,  1,  1,       0};
        vecs[4] = '{5, 8'h60, 16'hFEDC, 10, -1,  0,  -1,  92, 0,       64};
        vecs[5] = '{0, 8'hE0, 16'h5A5A, 0,  5,   3,  -1,  85, 0,       64};
        vecs[6] = '{3, 8'h00, 16'h3210, 0,  -1,  0,  24,  -1, 0,       17};
        vecs[7] = '{1, 8'h00, 16'h0F0F, 0,  -1,  0,  -1,  82, CK,      64};

        repeat (2) @(negedge clk);
        #1;
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_outputs", int'({data_ready, dp_hold, edit_sbox, sbox_sel, row_sel,
                                     col_sel, new_sbox_val, done, err}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        check("mem2_r0c0", int'(mem[2][0][0]), 0);
        check("mem2_r3c15", int'(mem[2][3][15]), 3);
        check("mem5_r2c6", int'(mem[5][2][6]), 4'hE);
        check("mem3_r1c0", int'(mem[3][1][0]), 0);
        check("mem3_r1c1_unwritten", int'(mem[3][1][1]), 4'hF);

        // Reset asserted in the middle of a load returns straight to IDLE
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cmd_valid  = (c == 0);
            cmd_sbox   = 3'd4;
            data_valid = 1'b1;
            data_word  = 16'h7777;
            dp_busy    = 1'b0;
        end
        @(negedge clk);
        #1;
        check("midload_writing", int'(edit_sbox), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd_ready", int'(cmd_ready), 1);
        check("midrst_hold", int'(dp_hold), 0);
        check("midrst_edit", int'(edit_sbox), 0);
        $display("midload reset cmd_ready=%0d dp_hold=%0d", cmd_ready, dp_hold);
        @(negedge clk);
        rst_n = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
